// File: rtl/line_feed_scheduler_if.sv
// Handshake and status bundle between the frame source and the line feed scheduler.
// Latency: none, wires only.
// Backpressure: o_s_ready qualifies i_s_valid; i_line_done returns one line credit.
interface line_feed_scheduler_if;
  logic       i_start;
  logic [7:0] i_s_data;
  logic       i_s_valid;
  logic       o_s_ready;
  logic [7:0] o_pixel_data;
  logic       o_pixel_data_valid;
  logic       i_line_done;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_err;

  // Frame source / downstream side: drives start, pixels and line-consumed pulses.
  modport master (
    output i_start, i_s_data, i_s_valid, i_line_done,
    input  o_s_ready, o_pixel_data, o_pixel_data_valid, o_busy, o_frame_done, o_err
  );

  // Scheduler side.
  modport slave (
    input  i_start, i_s_data, i_s_valid, i_line_done,
    output o_s_ready, o_pixel_data, o_pixel_data_valid, o_busy, o_frame_done, o_err
  );
endinterface

// File: rtl/line_feed_scheduler.sv
// Frame sequencer feeding the line-buffer write port, optional zero pad rows (LFS_EDGE_PAD_EN).
// Latency: pixel out registered, 1 cycle after the accepted or generated beat.
// Backpressure: a line may only start while fewer than NUM_LB buffers are allocated.
module line_feed_scheduler #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int NUM_LB     = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  line_feed_scheduler_if.slave bus
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int AW = $clog2(NUM_LB + 1);
  localparam int HW = $clog2(IMG_HEIGHT + 3);
`ifdef LFS_EDGE_PAD_EN
  localparam int DONE_EXP_I = IMG_HEIGHT;
`else
  localparam int DONE_EXP_I = IMG_HEIGHT - 2;
`endif
  localparam logic [HW-1:0] DONE_EXP  = DONE_EXP_I[HW-1:0];
  localparam logic [HW-1:0] ROW_LAST  = HW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] ALLOC_MAX = AW'(NUM_LB);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    DRAIN  = 3'd2
`ifdef LFS_EDGE_PAD_EN
    ,
    TOP_PAD = 3'd3,
    BOT_PAD = 3'd4
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [HW-1:0] row;
  logic [AW-1:0] alloc;
  logic [HW-1:0] done;

  logic          credit_ok;
  logic          pad_state;
  logic          stream_beat;
  logic          beat;
  logic          line_start;
  logic          line_end;
  logic          ld_ok;
  logic          dec;
  logic [HW-1:0] done_next;

  // Credit is judged on the registered alloc only, so a same-cycle line_done never grants a start.
  always_comb begin
    credit_ok = (col != '0) || (alloc < ALLOC_MAX);
`ifdef LFS_EDGE_PAD_EN
    pad_state = (state == TOP_PAD) || (state == BOT_PAD);
`else
    pad_state = 1'b0;
`endif
    stream_beat = (state == STREAM) && credit_ok && bus.i_s_valid;
    beat        = stream_beat || (pad_state && credit_ok);
    line_start  = beat && (col == '0);
    line_end    = beat && (col == COL_LAST);
    ld_ok       = bus.i_line_done && (state != IDLE);
    dec         = ld_ok && (alloc != '0);
    done_next   = done + HW'(ld_ok);
  end

  assign bus.o_s_ready = (state == STREAM) && credit_ok;

  // Frame FSM, beat counters, line credits and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state                  <= IDLE;
      col                    <= '0;
      row                    <= '0;
      alloc                  <= '0;
      done                   <= '0;
      bus.o_pixel_data       <= '0;
      bus.o_pixel_data_valid <= 1'b0;
      bus.o_busy             <= 1'b0;
      bus.o_frame_done       <= 1'b0;
      bus.o_err              <= 1'b0;
    end else begin
      bus.o_frame_done       <= 1'b0;
      bus.o_pixel_data_valid <= beat;
      bus.o_pixel_data       <= stream_beat ? bus.i_s_data : 8'd0;

      // A credit return with nothing allocated, or outside a frame, is a protocol slip.
      if (bus.i_line_done && ((state == IDLE) || (alloc == '0))) bus.o_err <= 1'b1;

      if (line_start && !dec)      alloc <= alloc + 1'b1;
      else if (!line_start && dec) alloc <= alloc - 1'b1;

      if (ld_ok) done <= done_next;
      if (beat)  col  <= (col == COL_LAST) ? '0 : col + 1'b1;

      case (state)
        IDLE: begin
          if (bus.i_start) begin
            bus.o_busy <= 1'b1;
            col        <= '0;
            row        <= '0;
            alloc      <= '0;
            done       <= '0;
`ifdef LFS_EDGE_PAD_EN
            state      <= TOP_PAD;
`else
            state      <= STREAM;
`endif
          end
        end
`ifdef LFS_EDGE_PAD_EN
        TOP_PAD: if (line_end) state <= STREAM;
`endif
        STREAM: begin
          if (line_end) begin
            if (row == ROW_LAST) begin
              row <= '0;
`ifdef LFS_EDGE_PAD_EN
              state <= BOT_PAD;
`else
              state <= DRAIN;
`endif
            end else begin
              row <= row + 1'b1;
            end
          end
        end
`ifdef LFS_EDGE_PAD_EN
        BOT_PAD: if (line_end) state <= DRAIN;
`endif
        DRAIN: begin
          // Lines left in the buffers when the window finishes are released with the frame.
          if (done_next >= DONE_EXP) begin
            state            <= IDLE;
            bus.o_busy       <= 1'b0;
            bus.o_frame_done <= 1'b1;
            alloc            <= '0;
            done             <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Self-checking bench for line_feed_scheduler: directed steps plus random pixel data and credit returns.
// Expected pixel stream is a queue built from accepted inputs and pad rows; credits checked by line arithmetic.
// Follows the build's LFS_EDGE_PAD_EN setting.
module tb_line_feed_scheduler;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int NLB = 4;
`ifdef LFS_EDGE_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int EXP_DONE  = PAD ? H : H - 2;
  localparam int LINES     = PAD ? H + 2 : H;
  localparam int EXP_ACC_1 = PAD ? (NLB - 1) * W : H * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  line_feed_scheduler_if bus ();

  line_feed_scheduler #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LB(NLB)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] q[$];
  int         n_acc, n_beats, n_done, fd_count;
  logic       last_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    n_acc = 0; n_beats = 0; n_done = 0; fd_count = 0; last_fd = 1'b0;
  endtask

  // One clock: drive inputs, let the edge pass, then score what the DUT produced.
  task automatic step(input logic v, input logic ld, input logic st);
    logic       acc;
    logic [7:0] d;
    logic [7:0] e;
    d = 8'($urandom);
    bus.i_s_valid   = v;
    bus.i_s_data    = d;
    bus.i_line_done = ld;
    bus.i_start     = st;
    acc = v & bus.o_s_ready & rst_n;
    if (acc) begin
      q.push_back(d);
      n_acc++;
      if (PAD && n_acc == H * W) for (int i = 0; i < W; i++) q.push_back(8'd0);
    end
    @(posedge clk);
    #1;
    bus.i_start     = 1'b0;
    bus.i_line_done = 1'b0;
    if (ld) n_done++;
    last_fd  = bus.o_frame_done;
    fd_count += int'(last_fd);
    if (acc) chk("latency", bus.o_pixel_data_valid, 1);
    if (bus.o_pixel_data_valid === 1'b1) begin
      chk("beat_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pixel", bus.o_pixel_data, e);
      end
      n_beats++;
    end
    chk("credit", ((n_beats + W - 1) / W) <= NLB + n_done, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic frame_begin();
    clear_model();
    if (PAD) for (int i = 0; i < W; i++) q.push_back(8'd0);
    step(0, 0, 1);
    chk("busy_after_start", bus.o_busy, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"}, bus.o_pixel_data, 0);
    chk({tag, "_valid"}, bus.o_pixel_data_valid, 0);
    chk({tag, "_ready"}, bus.o_s_ready, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_fdone"}, bus.o_frame_done, 0);
    chk({tag, "_err"}, bus.o_err, 0);
  endtask

  // Valid toggles every cycle; credits come back randomly once a few lines are held.
  task automatic run_random_frame(input string tag);
    logic v, ld;
    int   held;
    frame_begin();
    for (int c = 0; c < 400 && fd_count == 0; c++) begin
      v    = (c % 2) == 0;
      held = (n_beats + W - 1) / W - n_done;
      ld   = (n_done < EXP_DONE) && (held >= 3) && ($urandom_range(0, 1) == 1);
      step(v, ld, 0);
    end
    chk({tag, "_frame_done"}, fd_count, 1);
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_beats"}, n_beats, LINES * W);
    chk({tag, "_accepts"}, n_acc, H * W);
    chk({tag, "_busy_end"}, bus.o_busy, 0);
    chk({tag, "_err"}, bus.o_err, 0);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_s_data = 8'd0; bus.i_s_valid = 1'b0; bus.i_line_done = 1'b0;
    clear_model();

    // Reset state.
    do_reset();
    check_outputs_zero("reset");

    // Spurious credit return in IDLE: sticky error, no frame.
    step(0, 1, 0);
    chk("err_idle", bus.o_err, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("err_sticky", bus.o_err, 1);
    chk("idle_busy", bus.o_busy, 0);
    do_reset();
    chk("err_cleared", bus.o_err, 0);

    // Credit return with nothing allocated right after start.
    frame_begin();
    step(0, 1, 0);
    chk("err_alloc0", bus.o_err, 1);
    do_reset();
    chk("err_cleared2", bus.o_err, 0);

    // Continuous valid, no credits returned: fill every buffer then stall.
    frame_begin();
    for (int i = 0; i < 60; i++) step(1, 0, 0);
    chk("fill_beats", n_beats, NLB * W);
    chk("fill_accepts", n_acc, EXP_ACC_1);
    chk("fill_ready", bus.o_s_ready, 0);
    chk("fill_no_fdone", fd_count, 0);
    chk("fill_busy", bus.o_busy, 1);
`ifdef LFS_EDGE_PAD_EN
    // Credit returned while the next line start is pending: grant only on the following cycle.
    step(1, 1, 0);
    chk("same_cycle_ready", bus.o_s_ready, 1);
    chk("same_cycle_no_beat", bus.o_pixel_data_valid, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("line4_accepts", n_acc, H * W);
    chk("line4_beats", n_beats, (NLB + 1) * W);
    chk("botpad_stalled", bus.o_busy, 1);
`endif
    while (n_done < EXP_DONE) begin
      step(0, 1, 0);
      if (n_done == EXP_DONE) begin
        chk("fdone_after_last", last_fd, 1);
        chk("busy_fall", bus.o_busy, 0);
      end else begin
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        chk("no_early_fdone", fd_count, 0);
      end
    end
    chk("frame_beats", n_beats, LINES * W);
    chk("frame_queue", q.size(), 0);
    step(0, 0, 0);
    chk("fdone_one_cycle", bus.o_frame_done, 0);
    chk("frame_err", bus.o_err, 0);

    // Back-to-back frames with toggling valid.
    run_random_frame("rnd1");
    run_random_frame("rnd2");

    // Reset in the middle of the third stream line.
    do_reset();
    frame_begin();
    for (int i = 0; i < 100 && n_acc < 2 * W + 5; i++) step(1, 0, 0);
    chk("mid_accepts", n_acc, 2 * W + 5);
    rst_n = 1'b0;
    step(1, 0, 0);
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    run_random_frame("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
